ring_decoder_checker: RTL



---
 rtl/ring_pkg.sv | 16 +
 rtl/onehot_encoder.sv | 26 ++
 rtl/ring_decoder_checker.sv | 100 ++++++++++
 3 files changed

// File: rtl/ring_pkg.sv
// Shared types and helpers for ring-counter based blocks.
package ring_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    LOCKED
  } state_t;

  localparam int unsigned DEF_WIDTH = 4;

  function automatic int unsigned next_idx(input int unsigned i, input int unsigned w);
    return (i + 1) % w;
  endfunction

endpackage

// File: rtl/onehot_encoder.sv
// Combinational one-hot check and binary encode of a ring word.
module onehot_encoder
  import ring_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0]         din,
  output logic                     onehot,
  output logic [$clog2(WIDTH)-1:0] idx
);

  int unsigned ones;

  always_comb begin
    ones = 0;
    idx  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (din[i]) begin
        ones = ones + 1;
        idx  = ($clog2(WIDTH))'(i);
      end
    end
    onehot = (ones == 1);
  end

endmodule

// File: rtl/ring_decoder_checker.sv
// Ring word decoder with lock tracking and saturating violation counter.
module ring_decoder_checker
  import ring_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned ERR_W    = 8
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         din,
  input  logic                     en,
  input  logic                     clr_err,
  output logic [$clog2(WIDTH)-1:0] index,
  output logic                     idx_valid,
  output logic                     locked,
  output logic                     err,
  output logic [ERR_W-1:0]         err_count
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned GW = $clog2(LOCK_CNT + 1);

  state_t          state;
  logic [IW-1:0]   prev;
  logic [GW-1:0]   good_cnt;
  logic            onehot;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   expect_idx;
  logic            advance;

  onehot_encoder #(.WIDTH(WIDTH)) u_enc (
    .din    (din),
    .onehot (onehot),
    .idx    (idx)
  );

  assign expect_idx = IW'(next_idx(32'(prev), WIDTH));
  assign advance    = onehot && (idx == expect_idx);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prev      <= '0;
      good_cnt  <= '0;
      index     <= '0;
      idx_valid <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      err <= 1'b0;
      if (clr_err) err_count <= '0;
      if (en) begin
        idx_valid <= onehot;
        if (onehot) begin
          index <= idx;
          prev  <= idx;
        end
        case (state)
          IDLE: begin
            if (onehot) begin
              state    <= SEARCH;
              good_cnt <= '0;
            end
          end
          SEARCH: begin
            if (advance) begin
              good_cnt <= good_cnt + 1'b1;
              if (32'(good_cnt) + 1 == LOCK_CNT) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else if (onehot) begin
              good_cnt <= '0;
            end else begin
              state    <= IDLE;
              good_cnt <= '0;
            end
          end
          LOCKED: begin
            if (!advance) begin
              err      <= 1'b1;
              locked   <= 1'b0;
              good_cnt <= '0;
              state    <= onehot ? SEARCH : IDLE;
              // clr_err wins: the clear above stands and this violation is not counted
              if (!clr_err && err_count != '1) err_count <= err_count + 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
